// File: rtl/ifetch_unit.sv
// Instruction-fetch responder: samples the PC address, runs an im_req/im_ack read
// with a timeout, loads ir and issues a one-cycle enable_mem step per completed fetch.
//   state | meaning
//   IDLE  | waiting for enable_fetch; enable_mem follows branch_hold
//   BUSY  | im_req held, counting cycles until im_ack or timeout
//   DONE  | ir updated; one-cycle enable_mem / ir_valid pulse
module ifetch_unit #(
  parameter int memSize = 10,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [memSize-1:0] address,
  input  logic               enable_fetch,
  input  logic               branch_hold,
  output logic               im_req,
  output logic [memSize-1:0] im_addr,
  input  logic [31:0]        im_rdata,
  input  logic               im_ack,
  output logic [31:0]        ir,
  output logic               ir_valid,
  output logic               enable_mem,
  output logic               fetch_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      im_req     <= 1'b0;
      im_addr    <= '0;
      ir         <= 32'h0;
      ir_valid   <= 1'b0;
      enable_mem <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ir_valid <= 1'b0;
          im_req   <= 1'b0;
          if (branch_hold) begin
            enable_mem <= 1'b1;
          end else if (enable_fetch && (&address)) begin
            // PC reset bubble: complete a NOP fetch without touching memory
            ir         <= 32'h0;
            enable_mem <= 1'b1;
            ir_valid   <= 1'b1;
            state      <= DONE;
          end else if (enable_fetch) begin
            im_addr    <= address;
            im_req     <= 1'b1;
            cnt        <= '0;
            enable_mem <= 1'b0;
            state      <= BUSY;
          end else begin
            enable_mem <= 1'b0;
          end
        end
        BUSY: begin
          if (im_ack) begin
            ir         <= im_rdata;
            im_req     <= 1'b0;
            enable_mem <= 1'b1;
            ir_valid   <= 1'b1;
            state      <= DONE;
          end else if (cnt == CNT_LAST) begin
            ir         <= 32'h0;
            fetch_err  <= 1'b1;
            im_req     <= 1'b0;
            enable_mem <= 1'b1;
            ir_valid   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          enable_mem <= 1'b0;
          ir_valid   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
